// File: rtl/minmax_stream.sv
// Streaming min/max tracker: accumulates FRAME_LEN unsigned samples and presents min, max and their indices.
// Result valid the cycle after the final accept; in_ready drops while the result waits for out_ready.
module minmax_stream #(
  parameter  int BIT_WIDTH = 16,
  parameter  int FRAME_LEN = 8,
  localparam int IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [BIT_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BIT_WIDTH-1:0] out_min,
  output logic [BIT_WIDTH-1:0] out_max,
  output logic [IDX_W-1:0]     out_min_idx,
  output logic [IDX_W-1:0]     out_max_idx,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic {ACCUM, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     count;
  logic [BIT_WIDTH-1:0] min_r, max_r;
  logic [IDX_W-1:0]     min_idx_r, max_idx_r;
  logic                 accept;
  logic                 release_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    accept      = 1'b0;
    release_res = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        accept   = in_valid && !clear;
        if (accept && count == LAST_IDX) state_nxt = DONE;
      end
      DONE: begin
        out_valid   = 1'b1;
        release_res = out_ready;
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
    // clear overrides both the final accept and the result handshake
    if (clear) state_nxt = ACCUM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      min_r     <= '0;
      max_r     <= '0;
      min_idx_r <= '0;
      max_idx_r <= '0;
    end else if (clear || release_res) begin
      count <= '0;
    end else if (accept) begin
      if (count == '0) begin
        min_r     <= in_data;
        max_r     <= in_data;
        min_idx_r <= '0;
        max_idx_r <= '0;
      end else begin
        // strict compares keep the earliest index on ties
        if (in_data < min_r) begin
          min_r     <= in_data;
          min_idx_r <= count;
        end
        if (in_data > max_r) begin
          max_r     <= in_data;
          max_idx_r <= count;
        end
      end
      if (count != LAST_IDX) count <= count + IDX_W'(1);
    end
  end

  assign out_min     = min_r;
  assign out_max     = max_r;
  assign out_min_idx = min_idx_r;
  assign out_max_idx = max_idx_r;

endmodule

// File: tb/tb_minmax_stream.sv
// Directed bench for minmax_stream (BIT_WIDTH=16, FRAME_LEN=8) with immediate-assertion checks.
module tb_minmax_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_min, out_max;
  logic [2:0]  out_min_idx, out_max_idx;
  logic        out_valid;
  logic        out_ready;

  int tests = 0;
  int fails = 0;

  logic [15:0] frame [8];

  minmax_stream #(.BIT_WIDTH(16), .FRAME_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_min(out_min), .out_max(out_max),
    .out_min_idx(out_min_idx), .out_max_idx(out_max_idx),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input logic [15:0] mn, input logic [2:0] mni,
                              input logic [15:0] mx, input logic [2:0] mxi);
    check({tag, ".valid"},   32'(out_valid), 32'd1);
    check({tag, ".ready"},   32'(in_ready), 32'd0);
    check({tag, ".min"},     32'(out_min), 32'(mn));
    check({tag, ".min_idx"}, 32'(out_min_idx), 32'(mni));
    check({tag, ".max"},     32'(out_max), 32'(mx));
    check({tag, ".max_idx"}, 32'(out_max_idx), 32'(mxi));
  endtask

  // Drives frame[]; each sample waits (bounded) for in_ready, then is accepted at the next edge.
  task automatic send_frame(input bit bubbles);
    for (int i = 0; i < 8; i++) begin
      if (bubbles && i > 0) begin
        in_valid = 1'b0;
        step();
        step();
      end
      in_data  = frame[i];
      in_valid = 1'b1;
      for (int g = 0; g < 50 && !in_ready; g++) step();
      if (!in_ready) check("send.in_ready_timeout", 32'(in_ready), 32'd1);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic set_frame(input logic [15:0] a0, a1, a2, a3, a4, a5, a6, a7);
    frame[0] = a0; frame[1] = a1; frame[2] = a2; frame[3] = a3;
    frame[4] = a4; frame[5] = a5; frame[6] = a6; frame[7] = a7;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    #12;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.min", 32'(out_min), 32'd0);
    check("rst.max", 32'(out_max), 32'd0);
    check("rst.min_idx", 32'(out_min_idx), 32'd0);
    check("rst.max_idx", 32'(out_max_idx), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // basic frame: result visible right after the 8th accept, for exactly one cycle
    set_frame(3, 7, 1, 9, 4, 9, 1, 5);
    send_frame(1'b0);
    check_result("basic", 16'd1, 3'd2, 16'd9, 3'd3);
    step();
    check("basic.one_cycle", 32'(out_valid), 32'd0);
    check("basic.resume_ready", 32'(in_ready), 32'd1);

    set_frame(16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234);
    send_frame(1'b0);
    check_result("uniform", 16'h1234, 3'd0, 16'h1234, 3'd0);
    step();

    set_frame(16'hFFFF, 16'h0000, 16'h8000, 16'h0001, 16'h7FFF, 16'h8001, 16'hFFFE, 16'h0002);
    send_frame(1'b0);
    check_result("extreme", 16'h0000, 3'd1, 16'hFFFF, 3'd0);
    step();

    // backpressure: next frame's first sample held while the result waits
    out_ready = 1'b0;
    set_frame(5, 6, 7, 8, 1, 2, 3, 4);
    send_frame(1'b0);
    in_data  = 16'd100;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check_result("bp.hold", 16'd1, 3'd4, 16'd8, 3'd3);
      step();
    end
    out_ready = 1'b1;
    step();
    check("bp.release_valid", 32'(out_valid), 32'd0);
    check("bp.release_ready", 32'(in_ready), 32'd1);
    set_frame(100, 50, 200, 100, 10, 200, 60, 70);
    send_frame(1'b0);
    check_result("bp.frame2", 16'd10, 3'd4, 16'd200, 3'd2);
    step();

    set_frame(3, 7, 1, 9, 4, 9, 1, 5);
    send_frame(1'b1);
    check_result("bubbles", 16'd1, 3'd2, 16'd9, 3'd3);
    step();

    // clear after 5 accepts; the sample presented alongside clear must not count
    for (int i = 0; i < 5; i++) begin
      in_data = 16'(i);
      in_valid = 1'b1;
      step();
    end
    clear = 1'b1;
    in_data = 16'd0;
    step();
    clear = 1'b0;
    in_valid = 1'b0;
    check("clear.out_valid", 32'(out_valid), 32'd0);
    check("clear.in_ready", 32'(in_ready), 32'd1);
    set_frame(10, 11, 12, 13, 14, 15, 16, 17);
    send_frame(1'b0);
    check_result("clear.frame", 16'd10, 3'd0, 16'd17, 3'd7);
    step();

    // async reset while holding a result
    out_ready = 1'b0;
    set_frame(9, 8, 7, 6, 5, 4, 3, 2);
    send_frame(1'b0);
    check_result("prereset", 16'd2, 3'd7, 16'd9, 3'd0);
    rst_n = 1'b0;
    #1;
    check("arst.out_valid", 32'(out_valid), 32'd0);
    check("arst.in_ready", 32'(in_ready), 32'd1);
    check("arst.min", 32'(out_min), 32'd0);
    check("arst.max", 32'(out_max), 32'd0);
    check("arst.min_idx", 32'(out_min_idx), 32'd0);
    check("arst.max_idx", 32'(out_max_idx), 32'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    set_frame(20, 30, 25, 5, 40, 5, 40, 22);
    send_frame(1'b0);
    check_result("postreset", 16'd5, 3'd3, 16'd40, 3'd4);
    step();
    check("postreset.done", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
